vga_bounce_pic: RTL and testbench

//  Pixel source for vga_ctrl: an alternative to the colour-bar generator. Draws a

---
 rtl/vga_bounce_pic_pkg.sv | 47 ++++
 rtl/vga_bounce_pic_axis.sv | 68 ++++++
 rtl/vga_bounce_pic.sv | 102 ++++++++++
 tb/tb_vga_bounce_pic.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_bounce_pic_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_bounce_pic_pkg
// Brief  : Shared constants, types and palette lookup for the bouncing-square
//          pixel source (active area size, invalid coordinate, RGB565 colours).
// Rev    : 1.0  initial release
// ============================================================================
package vga_bounce_pic_pkg;

    localparam logic [9:0] H_VALID     = 10'd640;
    localparam logic [9:0] V_VALID     = 10'd480;
    localparam logic [9:0] INVALID_POS = 10'h3FF;

    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] ORANGE = 16'hFC00;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] CYAN   = 16'h07FF;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] PURPLE = 16'hF81F;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;

    // Direction of travel along one axis
    typedef enum logic [0:0] {
        MOVE_POS = 1'b0,
        MOVE_NEG = 1'b1
    } dir_t;

    // Square colour sequence, advanced once per bouncing update
    function automatic logic [15:0] palette(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RED;
            3'd1:    c = ORANGE;
            3'd2:    c = YELLOW;
            3'd3:    c = GREEN;
            3'd4:    c = CYAN;
            3'd5:    c = BLUE;
            3'd6:    c = PURPLE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_bounce_pic_axis.sv
`default_nettype none
// ============================================================================
// Module : vga_axis_bounce
// Brief  : One axis of the bouncing square. Moves pos by STEP on each update,
//          clamps at 0 / limit and reverses, flagging the bounce.
// Rev    : 1.0  initial release
// ============================================================================
module vga_axis_bounce
    import vga_bounce_pic_pkg::*;
#(
    parameter logic [9:0] STEP = 10'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic [10:0] limit,
    output logic [9:0]  pos,
    output logic        bounce
);

    dir_t        state;
    dir_t        state_nxt;
    logic [9:0]  pos_nxt;
    logic [10:0] nx;

    // Position and direction registers, restart at 0 heading positive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MOVE_POS;
            pos   <= 10'd0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    // Next position; edge reached exactly is clamped and counts as a bounce
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        bounce    = 1'b0;
        nx        = {1'b0, pos} + {1'b0, STEP};
        if (update) begin
            case (state)
                MOVE_POS: begin
                    if (nx >= limit) begin
                        pos_nxt   = limit[9:0];
                        state_nxt = MOVE_NEG;
                        bounce    = 1'b1;
                    end else begin
                        pos_nxt = nx[9:0];
                    end
                end
                default: begin
                    if (pos <= STEP) begin
                        pos_nxt   = 10'd0;
                        state_nxt = MOVE_POS;
                        bounce    = 1'b1;
                    end else begin
                        pos_nxt = pos - STEP;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_bounce_pic.sv
`default_nettype none
// ============================================================================
// Module : vga_bounce_pic
// Brief  : Pixel source drawing a solid square that bounces inside the active
//          area and changes colour on every bounce. RGB565 output, latency 1.
// Rev    : 1.0  initial release
// ============================================================================
module vga_bounce_pic #(
    parameter logic [9:0]  SQ_SIZE   = 10'd32,
    parameter logic [9:0]  STEP      = 10'd2,
    parameter logic [3:0]  FRAME_DIV = 4'd1,
    parameter logic [15:0] BG_COLOR  = 16'hFFFF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [15:0] pix_data
);
    import vga_bounce_pic_pkg::*;

    // A divider of 0 would never fire; run it as every frame instead
    localparam logic [3:0]  DIV     = (FRAME_DIV == 4'd0) ? 4'd1 : FRAME_DIV;
    localparam logic [10:0] X_LIMIT = {1'b0, H_VALID} - {1'b0, SQ_SIZE};
    localparam logic [10:0] Y_LIMIT = {1'b0, V_VALID} - {1'b0, SQ_SIZE};

    logic [3:0]  frame_cnt;
    logic [2:0]  col_idx;
    logic        tick;
    logic        update;
    logic [9:0]  sq_x;
    logic [9:0]  sq_y;
    logic        bounce_x;
    logic        bounce_y;
    logic [10:0] sq_x_end;
    logic [10:0] sq_y_end;
    logic        in_sq;

    // Tick on the last active pixel so moves land in blanking
    always_comb begin
        tick   = (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);
        update = tick && (frame_cnt == DIV - 4'd1);
    end

    // Frames-per-update divider
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            frame_cnt <= 4'd0;
        else if (update)
            frame_cnt <= 4'd0;
        else if (tick)
            frame_cnt <= frame_cnt + 4'd1;
    end

    vga_axis_bounce #(.STEP(STEP)) u_axis_x (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .update (update),
        .limit  (X_LIMIT),
        .pos    (sq_x),
        .bounce (bounce_x)
    );

    vga_axis_bounce #(.STEP(STEP)) u_axis_y (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .update (update),
        .limit  (Y_LIMIT),
        .pos    (sq_y),
        .bounce (bounce_y)
    );

    // One colour step per bouncing update, even when both axes bounce
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            col_idx <= 3'd0;
        else if (bounce_x || bounce_y)
            col_idx <= col_idx + 3'd1;
    end

    // Square hit test with 11-bit upper bounds so the end never wraps
    always_comb begin
        sq_x_end = {1'b0, sq_x} + {1'b0, SQ_SIZE};
        sq_y_end = {1'b0, sq_y} + {1'b0, SQ_SIZE};
        in_sq    = (pix_x >= sq_x) && ({1'b0, pix_x} < sq_x_end) &&
                   (pix_y >= sq_y) && ({1'b0, pix_y} < sq_y_end);
    end

    // Registered pixel colour: black outside the active area
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            pix_data <= 16'h0000;
        else if (pix_x == INVALID_POS || pix_y == INVALID_POS)
            pix_data <= 16'h0000;
        else if (in_sq)
            pix_data <= palette(col_idx);
        else
            pix_data <= BG_COLOR;
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_bounce_pic.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_bounce_pic
// Brief  : Self-checking bench for vga_bounce_pic; drives raw pix_x/pix_y and
//          forces frame ticks by presenting the last active pixel.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_bounce_pic;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic [15:0] pix_data3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vga_bounce_pic dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data)
    );

    vga_bounce_pic #(.FRAME_DIV(4'd3)) dut3 (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input logic [15:0] act, input logic [15:0] exp, input string nm);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a pixel for one edge, then sample 1 time unit after it
    task automatic apply(input logic [9:0] x, input logic [9:0] y);
        pix_x = x;
        pix_y = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] exp, input string nm);
        apply(x, y);
        compare(pix_data, exp, nm);
    endtask

    task automatic check3(input logic [9:0] x, input logic [9:0] y,
                          input logic [15:0] exp, input string nm);
        apply(x, y);
        compare(pix_data3, exp, nm);
    endtask

    // Each tick = last active pixel followed by one blanking cycle
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(10'd639, 10'd479);
            apply(10'h3FF, 10'h3FF);
        end
    endtask

    vec_t v_reset[6];
    vec_t v_frame1[4];

    initial begin
        v_reset[0] = '{10'd0,   10'd0,   16'hF800, "rst_pix_0_0"};
        v_reset[1] = '{10'd31,  10'd31,  16'hF800, "rst_pix_31_31"};
        v_reset[2] = '{10'd32,  10'd0,   16'hFFFF, "rst_pix_32_0"};
        v_reset[3] = '{10'd0,   10'd32,  16'hFFFF, "rst_pix_0_32"};
        v_reset[4] = '{10'h3FF, 10'd5,   16'h0000, "rst_pix_xinv"};
        v_reset[5] = '{10'd5,   10'h3FF, 16'h0000, "rst_pix_yinv"};

        v_frame1[0] = '{10'd1,  10'd1,  16'hFFFF, "f1_pix_1_1"};
        v_frame1[1] = '{10'd2,  10'd2,  16'hF800, "f1_pix_2_2"};
        v_frame1[2] = '{10'd33, 10'd33, 16'hF800, "f1_pix_33_33"};
        v_frame1[3] = '{10'd34, 10'd34, 16'hFFFF, "f1_pix_34_34"};

        rst_n = 1'b0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        compare(pix_data,  16'h0000, "reset_pix_data");
        compare(pix_data3, 16'h0000, "reset_pix_data3");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            check(v_reset[i].x, v_reset[i].y, v_reset[i].exp, v_reset[i].name);

        // Update 1: main square to (2,2); divided instance stays at (0,0)
        ticks(1);
        for (int i = 0; i < 4; i++)
            check(v_frame1[i].x, v_frame1[i].y, v_frame1[i].exp, v_frame1[i].name);
        check3(10'd0,  10'd0,  16'hF800, "div3_t1_0_0");
        check3(10'd32, 10'd32, 16'hFFFF, "div3_t1_32_32");
        ticks(1);
        check3(10'd0,  10'd0,  16'hF800, "div3_t2_0_0");
        check3(10'd32, 10'd32, 16'hFFFF, "div3_t2_32_32");
        ticks(1);
        check3(10'd0,  10'd0,  16'hFFFF, "div3_t3_0_0");
        check3(10'd2,  10'd2,  16'hF800, "div3_t3_2_2");
        check3(10'd33, 10'd33, 16'hF800, "div3_t3_33_33");

        // Main square now after 3 updates; run to 223 -> (446,446), still red
        ticks(220);
        check(10'd446, 10'd446, 16'hF800, "u223_in");
        check(10'd445, 10'd445, 16'hFFFF, "u223_out_lo");
        check(10'd478, 10'd478, 16'hFFFF, "u223_out_hi");
        // Update 224: bottom edge -> (448,448), orange
        ticks(1);
        check(10'd448, 10'd448, 16'hFC00, "u224_bottom_in");
        check(10'd479, 10'd479, 16'hFC00, "u224_bottom_last");
        check(10'd447, 10'd447, 16'hFFFF, "u224_bottom_out");
        // Update 303: (606,290)
        ticks(79);
        check(10'd606, 10'd290, 16'hFC00, "u303_in");
        check(10'd605, 10'd289, 16'hFFFF, "u303_out");
        // Update 304: right edge -> (608,288), yellow
        ticks(1);
        check(10'd608, 10'd288, 16'hFFE0, "u304_right_in");
        check(10'd639, 10'd319, 16'hFFE0, "u304_right_last");
        check(10'd607, 10'd287, 16'hFFFF, "u304_right_out");
        // Update 305: moving left -> (606,286)
        ticks(1);
        check(10'd606, 10'd286, 16'hFFE0, "u305_in");
        check(10'd637, 10'd286, 16'hFFE0, "u305_in_right");
        check(10'd638, 10'd286, 16'hFFFF, "u305_out_right");
        check(10'd605, 10'd286, 16'hFFFF, "u305_out_left");
        // Update 4255: (2,446), 31 bounce updates so far -> black
        ticks(3950);
        check(10'd2,  10'd446, 16'h0000, "u4255_in");
        check(10'd1,  10'd446, 16'hFFFF, "u4255_out");
        check(10'd34, 10'd477, 16'hFFFF, "u4255_out_hi");
        // Update 4256: corner (0,448), both axes bounce, one colour step -> red
        ticks(1);
        check(10'd0,  10'd448, 16'hF800, "corner_in");
        check(10'd31, 10'd479, 16'hF800, "corner_last");
        check(10'd0,  10'd447, 16'hFFFF, "corner_out");
        // Update 4257: leaves corner up-right -> (2,446)
        ticks(1);
        check(10'd2, 10'd446, 16'hF800, "post_corner_in");
        check(10'd1, 10'd446, 16'hFFFF, "post_corner_out");

        // Mid-line reset at (300,200)
        check(10'd300, 10'd200, 16'hFFFF, "pre_reset_bg");
        #2;
        rst_n = 1'b0;
        #1;
        compare(pix_data,  16'h0000, "async_reset_now");
        compare(pix_data3, 16'h0000, "async_reset_now3");
        @(posedge clk);
        #1;
        compare(pix_data, 16'h0000, "reset_held");
        rst_n = 1'b1;
        check(10'd0,  10'd0,  16'hF800, "rel_pix_0_0");
        check(10'd31, 10'd31, 16'hF800, "rel_pix_31_31");
        check(10'd32, 10'd32, 16'hFFFF, "rel_pix_32_32");
        ticks(1);
        check(10'd2, 10'd2, 16'hF800, "rel_u1_in");
        check(10'd1, 10'd1, 16'hFFFF, "rel_u1_out");
        check3(10'd0, 10'd0, 16'hF800, "rel_div3_t1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
